efuse_macro_emu: RTL and testbench
==================================

# efuse_macro_emu

Synthesizable behavioural emulator of the 256-bit eFuse macro. It is the responder end of the pgmen/rden/aen/addr/rdata interface driven by the eFuse controller. The emulator decodes read and program strobes and holds a one-time-programmable bit array. It also checks the strobe timing, so FPGA prototypes and block-level benches can run the controller against a macro without the hard IP. It sits directly on the controller's `efuse_*_o` outputs and returns `efuse_rdata_i`.

## Interface
- `INIT`, 256'h0, array contents after reset (bit n = fuse n)
- `TRD_MIN`, 2, minimum aen-high cycles for a valid read strobe
- `TPGM_MIN`, 10, minimum aen-high cycles for a valid program strobe
- `clk`  in  1  single clock, same domain as the controller
- `rst`  in  1  asynchronous, active-high reset
- `efuse_pgmen_i`  in  1  program mode enable
- `efuse_rden_i`  in  1  read mode enable
- `efuse_aen_i`  in  1  address strobe
- `efuse_addr_i`  in  8  program: bit index 0..255; read: byte index in [4:0], [7:5] must be 0
- `efuse_rdata_o`  out  8  last read byte
- `prog_cnt`  out  9  number of fuses newly blown since reset, 0..256
- `err_timing`  out  1  sticky: short strobe or mode change during strobe
- `err_mode`  out  1  sticky: pgmen and rden both high
- `err_addr`  out  1  sticky: read with addr[7:5] != 0
- `err_clr`  in  1  single-cycle clear of all sticky errors

## Operation
- Inputs are synchronous to `clk`; no synchronizers. Each input is sampled once per rising edge.
- FSM states: IDLE, RD_ARM, RD_STB, PG_ARM, PG_STB.
  - IDLE → RD_ARM when rden=1, pgmen=0, aen=0.
  - IDLE → PG_ARM when pgmen=1, rden=0, aen=0.
  - ARM → STB on aen=1. The strobe counter loads 1 and `addr_q` latches `efuse_addr_i`.
  - STB: the counter increments each cycle aen=1 and saturates at 1023.
  - STB → ARM on aen=0. This edge is the commit edge.
  - ARM → IDLE when its enable drops.
- Address changes while in STB are ignored; `addr_q` is used.
- Read commit, count ≥ TRD_MIN: `efuse_rdata_o` ← array[addr_q[4:0]*8 +: 8], LSB = lowest bit index.
  - Count < TRD_MIN: rdata unchanged; set err_timing.
  - addr_q[7:5] ≠ 0: rdata ← 8'h00; set err_addr.
- Program commit, count ≥ TPGM_MIN: array[addr_q] ← 1.
  - `prog_cnt` increments only if that bit was 0.
  - Already-blown bit: no change, no error.
  - Count < TPGM_MIN: array unchanged; set err_timing.
- Bits are never cleared except by `rst`. Reset reloads `INIT`; this is an emulator property, not macro behaviour.
- pgmen=1 and rden=1 in the same cycle, in any state:
  - Set err_mode and go to IDLE.
  - Abort any strobe without commit.
  - Return to IDLE until both enables are 0.
- Enable drops while in STB (aen still 1): abort without commit, set err_timing, go to IDLE.
- aen=1 sampled in IDLE (no enable): ignored, no error.
- err_clr and a new error event in the same cycle: the error wins (flag stays 1).

## Timing
- Reset values:
  - `efuse_rdata_o` = 8'h00
  - `prog_cnt` = 0
  - all err_* = 0
  - FSM in IDLE
  - counter = 0
  - array = INIT
- Strobe width W = number of rising edges at which aen_i is sampled 1.
- Commit occurs at the first edge sampling aen_i=0.
  - `efuse_rdata_o`, `prog_cnt` and array bits update at that edge, visible in the following cycle.
  - A read strobe starting the cycle after a program commit sees the new bit.
- Sticky flags assert on the edge that detects the condition.
- Back-to-back strobes are legal: aen may rise again the cycle after it is sampled low, with a minimum 1-cycle aen-low gap.
- `rst` asserted mid-strobe: immediate abort, no commit, array = INIT, all outputs at reset values.

## Test plan
- INIT=256'h…A5 in byte 3, i.e. bits [31:24]=8'hA5. rden=1, addr=8'h03, aen high 2 cycles → efuse_rdata_o=8'hA5 the cycle after aen falls; no errors.
- INIT=0. pgmen=1, addr=8'h11, aen high 10 cycles → prog_cnt=1. Then read addr=8'h02 → rdata=8'h02. Program bit 8'h11 again → prog_cnt stays 1.
- pgmen=1, addr=8'h40, aen high 9 cycles (TPGM_MIN−1) → err_timing=1, prog_cnt=0. A read of byte 8 returns 8'h00. Pulse err_clr → err_timing=0.
- rden and pgmen both 1 while in RD_STB → err_mode=1, rdata unchanged, no commit. Issue err_clr while the conflict persists → err_mode stays 1.
- rden=1, addr=8'h25, aen 3 cycles → rdata=8'h00, err_addr=1.
- Assert rst during cycle 5 of a 10-cycle program strobe on bit 0 → prog_cnt=0, bit 0 reads back 0, FSM IDLE; the next valid program of bit 0 succeeds.

Source files
------------

// File: rtl/efuse_macro_emu.sv
// efuse_macro_emu: behavioural stand-in for the 256-bit one-time-programmable
// eFuse macro. It answers the controller's pgmen/rden/aen/addr strobes, holds
// the fuse array, and flags strobes that would be illegal on the real macro.
//
// Strobe protocol: the controller raises exactly one mode enable (rden or
// pgmen) while aen is low, then holds aen high for W edges with the address
// valid on the first of them. The first edge that samples aen low commits the
// operation. The enable must stay high until that commit edge. Raising both
// enables, dropping the enable mid-strobe, or a strobe shorter than the mode
// minimum is reported through the sticky error flags instead.
module efuse_macro_emu #(
    parameter logic [255:0] INIT     = 256'h0,
    parameter int           TRD_MIN  = 2,
    parameter int           TPGM_MIN = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       efuse_pgmen_i,
    input  logic       efuse_rden_i,
    input  logic       efuse_aen_i,
    input  logic [7:0] efuse_addr_i,
    output logic [7:0] efuse_rdata_o,
    output logic [8:0] prog_cnt,
    output logic       err_timing,
    output logic       err_mode,
    output logic       err_addr,
    input  logic       err_clr,
    output logic [2:0] dbg_state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD_ARM = 3'd1;
    localparam logic [2:0] S_RD_STB = 3'd2;
    localparam logic [2:0] S_PG_ARM = 3'd3;
    localparam logic [2:0] S_PG_STB = 3'd4;

    localparam logic [9:0] CNT_MAX     = 10'd1023;
    localparam logic [9:0] TRD_MIN_C   = TRD_MIN[9:0];
    localparam logic [9:0] TPGM_MIN_C  = TPGM_MIN[9:0];

    logic [2:0]   state_q, state_d;
    logic         lock_q, lock_d;    // set by a mode conflict, held until both enables are low
    logic [9:0]   cnt_q, cnt_d;      // aen-high edges seen in the current strobe
    logic [7:0]   addr_q, addr_d;    // address captured on the first strobe edge
    logic [255:0] fuse_q;

    logic conflict;
    logic rd_commit, pg_commit, abort_evt;
    logic rd_ok, pg_ok, addr_bad;
    logic [7:0] rd_byte;

    assign conflict  = efuse_pgmen_i & efuse_rden_i;
    assign rd_ok     = (cnt_q >= TRD_MIN_C);
    assign pg_ok     = (cnt_q >= TPGM_MIN_C);
    assign addr_bad  = |addr_q[7:5];
    assign rd_byte   = fuse_q[{addr_q[4:0], 3'b000} +: 8];
    assign dbg_state = state_q;

    // Next-state decode: mode arming, strobe counting, commit and abort detection.
    always_comb begin
        state_d   = state_q;
        lock_d    = lock_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        rd_commit = 1'b0;
        pg_commit = 1'b0;
        abort_evt = 1'b0;
        if (conflict) begin
            state_d = S_IDLE;
            lock_d  = 1'b1;
            cnt_d   = 10'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!efuse_pgmen_i && !efuse_rden_i) begin
                        lock_d = 1'b0;
                    end else if (!lock_q && !efuse_aen_i) begin
                        state_d = efuse_rden_i ? S_RD_ARM : S_PG_ARM;
                    end
                end
                S_RD_ARM: begin
                    if (!efuse_rden_i) begin
                        state_d = S_IDLE;
                    end else if (efuse_aen_i) begin
                        state_d = S_RD_STB;
                        cnt_d   = 10'd1;
                        addr_d  = efuse_addr_i;
                    end
                end
                S_RD_STB: begin
                    if (!efuse_rden_i) begin
                        state_d   = S_IDLE;
                        cnt_d     = 10'd0;
                        abort_evt = 1'b1;
                    end else if (efuse_aen_i) begin
                        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 10'd1;
                    end else begin
                        state_d   = S_RD_ARM;
                        cnt_d     = 10'd0;
                        rd_commit = 1'b1;
                    end
                end
                S_PG_ARM: begin
                    if (!efuse_pgmen_i) begin
                        state_d = S_IDLE;
                    end else if (efuse_aen_i) begin
                        state_d = S_PG_STB;
                        cnt_d   = 10'd1;
                        addr_d  = efuse_addr_i;
                    end
                end
                S_PG_STB: begin
                    if (!efuse_pgmen_i) begin
                        state_d   = S_IDLE;
                        cnt_d     = 10'd0;
                        abort_evt = 1'b1;
                    end else if (efuse_aen_i) begin
                        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 10'd1;
                    end else begin
                        state_d   = S_PG_ARM;
                        cnt_d     = 10'd0;
                        pg_commit = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = 10'd0;
                end
            endcase
        end
    end

    // FSM, strobe counter and captured address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            lock_q  <= 1'b0;
            cnt_q   <= 10'd0;
            addr_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

    // Fuse array, read data and blown-fuse counter, all updated on commit edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fuse_q        <= INIT;
            efuse_rdata_o <= 8'h00;
            prog_cnt      <= 9'd0;
        end else begin
            if (rd_commit && rd_ok) begin
                efuse_rdata_o <= addr_bad ? 8'h00 : rd_byte;
            end
            if (pg_commit && pg_ok && !fuse_q[addr_q]) begin
                fuse_q[addr_q] <= 1'b1;
                prog_cnt       <= prog_cnt + 9'd1;
            end
        end
    end

    // Sticky error flags; a new event outranks a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_timing <= 1'b0;
            err_mode   <= 1'b0;
            err_addr   <= 1'b0;
        end else begin
            err_timing <= abort_evt | (rd_commit & ~rd_ok) | (pg_commit & ~pg_ok)
                          | (err_timing & ~err_clr);
            err_mode   <= conflict | (err_mode & ~err_clr);
            err_addr   <= (rd_commit & addr_bad) | (err_addr & ~err_clr);
        end
    end

endmodule

// File: tb/tb_efuse_macro_emu.sv
// tb_efuse_macro_emu: directed vector table, hand-written corner sequences and
// randomized transactions checked against a transaction-level fuse model.
module tb_efuse_macro_emu;

    localparam int TRD  = 2;
    localparam int TPGM = 10;
    localparam logic [255:0] INIT_V = 256'hA5 << 24;

    // Clock/reset and DUT signals
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pgmen = 1'b0, rden = 1'b0, aen = 1'b0, err_clr = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] rdata;
    logic [8:0] prog_cnt;
    logic       err_timing, err_mode, err_addr;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    efuse_macro_emu #(.INIT(INIT_V), .TRD_MIN(TRD), .TPGM_MIN(TPGM)) dut (
        .clk(clk), .rst(rst),
        .efuse_pgmen_i(pgmen), .efuse_rden_i(rden), .efuse_aen_i(aen),
        .efuse_addr_i(addr), .efuse_rdata_o(rdata), .prog_cnt(prog_cnt),
        .err_timing(err_timing), .err_mode(err_mode), .err_addr(err_addr),
        .err_clr(err_clr), .dbg_state(dbg_state)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: fuse bits and the visible results of each transaction
    logic [255:0] m_fuse;
    logic [7:0]   m_rd;
    int           m_cnt;
    logic         m_et, m_em, m_ea;

    task automatic m_reset();
        m_fuse = INIT_V; m_rd = 8'h00; m_cnt = 0; m_et = 0; m_em = 0; m_ea = 0;
    endtask

    task automatic m_read(input logic [7:0] a, input int w);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) b[k] = m_fuse[int'(a[4:0]) * 8 + k];
        if (a >= 8'd32) m_ea = 1;
        if (w < TRD) m_et = 1;
        else m_rd = (a >= 8'd32) ? 8'h00 : b;
    endtask

    task automatic m_prog(input logic [7:0] a, input int w);
        if (w < TPGM) m_et = 1;
        else if (!m_fuse[a]) begin
            m_fuse[a] = 1'b1;
            m_cnt++;
        end
    endtask

    // Scoreboard compare
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_outs(input string nm, input logic [7:0] rd, input int cnt, input logic [2:0] e);
        chk({nm, ".rdata"}, 32'(rdata), 32'(rd));
        chk({nm, ".prog_cnt"}, 32'(prog_cnt), 32'(cnt));
        chk({nm, ".err"}, 32'({err_timing, err_mode, err_addr}), 32'(e));
        chk({nm, ".state"}, 32'(dbg_state), 32'd0);
    endtask

    task automatic chk_model(input string nm);
        chk_outs(nm, m_rd, m_cnt, {m_et, m_em, m_ea});
    endtask

    // Driver tasks: inputs change on the falling edge, DUT samples on the rising edge
    task automatic open_mode(input bit is_prog);
        @(negedge clk);
        pgmen = is_prog; rden = !is_prog; aen = 1'b0;
    endtask

    task automatic strobe(input logic [7:0] a, input int w);
        for (int k = 0; k < w; k++) begin
            @(negedge clk);
            aen = 1'b1;
            addr = (k == 0) ? a : 8'($urandom);
        end
        @(negedge clk);
        aen = 1'b0;
        addr = 8'($urandom);
    endtask

    task automatic close_mode();
        @(negedge clk);
        pgmen = 1'b0; rden = 1'b0; aen = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_txn(input bit is_prog, input logic [7:0] a, input int w);
        open_mode(is_prog);
        strobe(a, w);
        close_mode();
        if (is_prog) m_prog(a, w); else m_read(a, w);
    endtask

    task automatic do_b2b(input bit is_prog, input logic [7:0] a1, input int w1,
                          input logic [7:0] a2, input int w2);
        open_mode(is_prog);
        strobe(a1, w1);
        strobe(a2, w2);
        close_mode();
        if (is_prog) begin m_prog(a1, w1); m_prog(a2, w2); end
        else begin m_read(a1, w1); m_read(a2, w2); end
    endtask

    task automatic pulse_clr();
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        m_et = 0; m_em = 0; m_ea = 0;
    endtask

    // Directed vector table: op 0=read, 1=program, 2=clear errors
    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        int         w;
        logic [7:0] rd;
        int         cnt;
        logic [2:0] err;   // {timing, mode, addr}
    } vec_t;

    vec_t tbl[18];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{2'd0, 8'h03, 2,  8'hA5, 0, 3'b000};
        tbl[1]  = '{2'd1, 8'h11, 10, 8'hA5, 1, 3'b000};
        tbl[2]  = '{2'd0, 8'h02, 2,  8'h02, 1, 3'b000};
        tbl[3]  = '{2'd1, 8'h11, 10, 8'h02, 1, 3'b000};
        tbl[4]  = '{2'd1, 8'h40, 9,  8'h02, 1, 3'b100};
        tbl[5]  = '{2'd0, 8'h08, 2,  8'h00, 1, 3'b100};
        tbl[6]  = '{2'd2, 8'h00, 0,  8'h00, 1, 3'b000};
        tbl[7]  = '{2'd0, 8'h25, 3,  8'h00, 1, 3'b001};
        tbl[8]  = '{2'd2, 8'h00, 0,  8'h00, 1, 3'b000};
        tbl[9]  = '{2'd0, 8'h03, 2,  8'hA5, 1, 3'b000};
        tbl[10] = '{2'd0, 8'h02, 1,  8'hA5, 1, 3'b100};
        tbl[11] = '{2'd2, 8'h00, 0,  8'hA5, 1, 3'b000};
        tbl[12] = '{2'd1, 8'hFF, 12, 8'hA5, 2, 3'b000};
        tbl[13] = '{2'd0, 8'h1F, 2,  8'h80, 2, 3'b000};
        tbl[14] = '{2'd1, 8'h00, 10, 8'h80, 3, 3'b000};
        tbl[15] = '{2'd0, 8'h00, 2,  8'h01, 3, 3'b000};
        tbl[16] = '{2'd1, 8'h41, 10, 8'h01, 4, 3'b000};
        tbl[17] = '{2'd0, 8'h08, 2,  8'h02, 4, 3'b000};

        m_reset();

        // Reset state
        @(negedge clk);
        chk_outs("reset", 8'h00, 0, 3'b000);
        rst = 1'b0;

        // Table-driven directed vectors
        for (int i = 0; i < 18; i++) begin
            if (tbl[i].op == 2'd2) pulse_clr();
            else do_txn(tbl[i].op == 2'd1, tbl[i].a, tbl[i].w);
            chk_outs($sformatf("tbl%0d", i), tbl[i].rd, tbl[i].cnt, tbl[i].err);
        end

        // Mode conflict during a read strobe: no commit, clear cannot win, lockout
        open_mode(1'b0);
        @(negedge clk); aen = 1'b1; addr = 8'h03;
        @(negedge clk);
        @(negedge clk); pgmen = 1'b1;
        @(negedge clk);
        m_em = 1;
        chk_outs("conflict", m_rd, m_cnt, {m_et, m_em, m_ea});
        err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        chk("conflict_clr_loses", 32'(err_mode), 32'd1);
        pgmen = 1'b0; aen = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("conflict_lockout_state", 32'(dbg_state), 32'd0);
        rden = 1'b0;
        @(negedge clk);
        pulse_clr();
        chk_model("conflict_cleared");

        // Enable dropped mid program strobe: abort, timing error, no fuse blown
        open_mode(1'b1);
        for (int k = 0; k < 5; k++) begin @(negedge clk); aen = 1'b1; addr = 8'h80; end
        @(negedge clk); pgmen = 1'b0;
        @(negedge clk); aen = 1'b0;
        @(negedge clk);
        m_et = 1;
        chk_model("en_drop");
        do_txn(1'b0, 8'h10, 2);
        chk_model("en_drop_readback");
        pulse_clr();

        // aen toggling with no mode enabled is ignored
        for (int k = 0; k < 3; k++) begin @(negedge clk); aen = 1'b1; addr = 8'($urandom); end
        @(negedge clk); aen = 1'b0;
        @(negedge clk);
        chk_model("idle_aen");

        // Clear coinciding with a new short-strobe error: error stays set
        do_txn(1'b0, 8'h00, 1);
        open_mode(1'b0);
        @(negedge clk); aen = 1'b1; addr = 8'h00;
        @(negedge clk); aen = 1'b0; err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        close_mode();
        m_et = 0; m_em = 0; m_ea = 0;
        m_read(8'h00, 1);
        chk_model("clr_vs_err");
        pulse_clr();

        // Reset during the fifth cycle of a program strobe on bit 0
        open_mode(1'b1);
        for (int k = 0; k < 4; k++) begin @(negedge clk); aen = 1'b1; addr = 8'h00; end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; aen = 1'b0; pgmen = 1'b0;
        m_reset();
        chk_outs("mid_rst", 8'h00, 0, 3'b000);
        do_txn(1'b0, 8'h00, 2);
        chk_outs("mid_rst_bit0", 8'h00, 0, 3'b000);
        do_txn(1'b0, 8'h03, 2);
        chk_outs("mid_rst_init", 8'hA5, 0, 3'b000);
        do_txn(1'b1, 8'h00, 10);
        do_txn(1'b0, 8'h00, 2);
        chk_outs("mid_rst_reprog", 8'h01, 1, 3'b000);

        // Very long strobe drives the counter into saturation and still commits
        do_txn(1'b1, 8'h05, 1100);
        chk_model("long_strobe");

        // Randomized transactions against the model
        for (int i = 0; i < 200; i++) begin
            int sel;
            bit is_prog;
            logic [7:0] a1, a2;
            int w1, w2;
            sel = $urandom_range(0, 9);
            is_prog = 1'($urandom_range(0, 1));
            a1 = is_prog ? 8'($urandom_range(0, 255))
                         : (($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31)));
            a2 = is_prog ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 31));
            w1 = is_prog ? $urandom_range(7, 13) : $urandom_range(1, 4);
            w2 = is_prog ? $urandom_range(7, 13) : $urandom_range(1, 4);
            if (sel == 0) pulse_clr();
            else if (sel <= 2) do_b2b(is_prog, a1, w1, a2, w2);
            else do_txn(is_prog, a1, w1);
            chk_model($sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
